rpn_controller: RTL and testbench

Key-driven sequencer that sits directly upstream of the calculator's 64-entry operand stack. It accepts one key code at a time, builds decimal numbers into the stack top, and executes ENTER, CLEAR and the binary operators + − × ÷ as legal push/pop/write sequences on the stack. Division uses a 32-cycle restoring divider; every other operation takes 1–3 cycles.

---
 rtl/rpn_controller_if.sv | 28 ++
 rtl/rpn_controller.sv | 179 +++++++++++++++++
 tb/tb_rpn_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_controller_if.sv
// Key handshake plus operand-stack strobes between the RPN sequencer and
// its surroundings (key source and 64-entry stack).
interface rpn_controller_if;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic [31:0] stack_top;
    logic [31:0] stack_next;
    logic [5:0]  stack_count;
    logic        push;
    logic        pop;
    logic        write;
    logic [31:0] value;
    logic        busy;
    logic        err;

    // master: the controller itself
    modport master (
        input  key_valid, key_code, stack_top, stack_next, stack_count,
        output key_ready, push, pop, write, value, busy, err
    );

    // slave: key source and stack
    modport slave (
        output key_valid, key_code, stack_top, stack_next, stack_count,
        input  key_ready, push, pop, write, value, busy, err
    );
endinterface

// File: rtl/rpn_controller.sv
// RPN key sequencer: turns key codes into push/pop/write sequences on the
// operand stack. Arithmetic results are computed at key acceptance except
// division, which runs a 32-iteration restoring divider.
module rpn_controller (
    input  logic             clock,
    input  logic             reset_n,
    rpn_controller_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_WR, S_POP, S_DIV} state_t;

    state_t      state_q, state_d;
    logic        wr_after_push_q, wr_after_push_d;
    logic        entry_q, entry_d;
    logic        err_q, err_d;
    logic [31:0] value_q, value_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [4:0]  iter_q, iter_d;
    logic        push_q, push_d;
    logic        pop_q, pop_d;
    logic        write_q, write_d;
    logic        key_ready_q, key_ready_d;
    logic        busy_q, busy_d;

    logic        stack_full;
    logic        operands_ok;
    logic [31:0] digit;
    logic [31:0] entry_value;
    logic [31:0] product;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;

    // count 0 encodes a full stack; a binary op needs two elements
    assign stack_full  = (bus.stack_count == 6'd0);
    assign operands_ok = (bus.stack_count != 6'd1);
    assign digit       = {27'd0, bus.key_code};
    assign entry_value = bus.stack_top * 32'd10 + digit;
    assign product     = bus.stack_next * bus.stack_top;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits.
    assign rem_shift = {rem_q, quot_q[31]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
    assign rem_sub   = rem_shift[31:0] - divisor_q;

    // Next-state and next-output decode for the key sequencer
    always_comb begin
        state_d         = state_q;
        wr_after_push_d = wr_after_push_q;
        entry_d         = entry_q;
        err_d           = err_q;
        value_d         = value_q;
        quot_d          = quot_q;
        rem_d           = rem_q;
        divisor_d       = divisor_q;
        iter_d          = iter_q;

        case (state_q)
            S_IDLE: begin
                if (bus.key_valid) begin
                    if (bus.key_code <= 5'd9) begin
                        if (entry_q) begin
                            value_d = entry_value;
                            state_d = S_WR;
                        end else if (!stack_full) begin
                            value_d         = digit;
                            wr_after_push_d = 1'b1;
                            entry_d         = 1'b1;
                            state_d         = S_PUSH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_code <= 5'd13) begin
                        if (!operands_ok) begin
                            err_d = 1'b1;
                        end else begin
                            entry_d = 1'b0;
                            state_d = S_POP;
                            case (bus.key_code)
                                5'd10:   value_d = bus.stack_next + bus.stack_top;
                                5'd11:   value_d = bus.stack_next - bus.stack_top;
                                5'd12:   value_d = product;
                                default: begin
                                    if (bus.stack_top == 32'd0) begin
                                        value_d = 32'd0;
                                        err_d   = 1'b1;
                                    end else begin
                                        quot_d    = bus.stack_next;
                                        rem_d     = 32'd0;
                                        divisor_d = bus.stack_top;
                                        iter_d    = 5'd0;
                                        state_d   = S_DIV;
                                    end
                                end
                            endcase
                        end
                    end else if (bus.key_code == 5'd14) begin
                        if (!stack_full) begin
                            wr_after_push_d = 1'b0;
                            entry_d         = 1'b1;
                            state_d         = S_PUSH;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (bus.key_code == 5'd15) begin
                        value_d = 32'd0;
                        err_d   = 1'b0;
                        entry_d = 1'b1;
                        state_d = S_WR;
                    end
                end
            end
            S_PUSH:  state_d = wr_after_push_q ? S_WR : S_IDLE;
            S_WR:    state_d = S_IDLE;
            S_POP:   state_d = S_WR;
            S_DIV: begin
                quot_d = {quot_q[30:0], rem_ge};
                rem_d  = rem_ge ? rem_sub : rem_shift[31:0];
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    value_d = {quot_q[30:0], rem_ge};
                    state_d = S_POP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        push_d      = (state_d == S_PUSH);
        pop_d       = (state_d == S_POP);
        write_d     = (state_d == S_WR);
        key_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // Register state, datapath and Moore strobes; reset abandons any sequence
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            wr_after_push_q <= 1'b0;
            entry_q         <= 1'b1;
            err_q           <= 1'b0;
            value_q         <= 32'd0;
            quot_q          <= 32'd0;
            rem_q           <= 32'd0;
            divisor_q       <= 32'd0;
            iter_q          <= 5'd0;
            push_q          <= 1'b0;
            pop_q           <= 1'b0;
            write_q         <= 1'b0;
            key_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_after_push_q <= wr_after_push_d;
            entry_q         <= entry_d;
            err_q           <= err_d;
            value_q         <= value_d;
            quot_q          <= quot_d;
            rem_q           <= rem_d;
            divisor_q       <= divisor_d;
            iter_q          <= iter_d;
            push_q          <= push_d;
            pop_q           <= pop_d;
            write_q         <= write_d;
            key_ready_q     <= key_ready_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.push      = push_q;
    assign bus.pop       = pop_q;
    assign bus.write     = write_q;
    assign bus.value     = value_q;
    assign bus.key_ready = key_ready_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_rpn_controller.sv
// Bench for rpn_controller: a 64-entry stack model driven by the DUT strobes
// and a queue-based calculator reference model updated per accepted key.
module tb_rpn_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b1;

    rpn_controller_if bus ();

    rpn_controller dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #10 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int last_lat = 0;

    // ---------------- stack model driven by the DUT ----------------
    logic [31:0] mem [64] = '{default: 32'd0};
    int          stk_cnt  = 1;
    int          stk_bad  = 0;
    int          multi    = 0;

    always @(posedge clock) begin
        if (int'(bus.push) + int'(bus.pop) + int'(bus.write) > 1) multi <= multi + 1;
        if (bus.push) begin
            if (stk_cnt >= 64) stk_bad <= stk_bad + 1;
            else begin
                mem[6'(stk_cnt)] <= 32'd0;
                stk_cnt <= stk_cnt + 1;
            end
        end else if (bus.pop) begin
            if (stk_cnt <= 0) stk_bad <= stk_bad + 1;
            else stk_cnt <= stk_cnt - 1;
        end else if (bus.write) begin
            if (stk_cnt <= 0) stk_bad <= stk_bad + 1;
            else mem[6'(stk_cnt - 1)] <= bus.value;
        end
    end

    assign bus.stack_top   = (stk_cnt >= 1) ? mem[6'(stk_cnt - 1)] : 32'd0;
    assign bus.stack_next  = (stk_cnt >= 2) ? mem[6'(stk_cnt - 2)] : 32'd0;
    assign bus.stack_count = 6'(stk_cnt);

    // ---------------- reference calculator ----------------
    logic [31:0] ref_stk [$] = '{32'd0};
    logic        ref_entry = 1'b1;
    logic        ref_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one key to the reference; lat is the number of busy cycles.
    task automatic model_key(input logic [4:0] k, output int lat);
        logic [31:0] a, b, r;
        int sz;
        sz  = ref_stk.size();
        lat = 0;
        r   = 32'd0;
        if (k <= 5'd9) begin
            if (ref_entry) begin
                ref_stk[sz-1] = ref_stk[sz-1] * 32'd10 + {27'd0, k};
                lat = 1;
            end else if (sz < 64) begin
                ref_stk.push_back({27'd0, k});
                ref_entry = 1'b1;
                lat = 2;
            end else ref_err = 1'b1;
        end else if (k <= 5'd13) begin
            if (sz == 1) ref_err = 1'b1;
            else begin
                b = ref_stk.pop_back();
                a = ref_stk.pop_back();
                lat = 2;
                case (k)
                    5'd10: r = a + b;
                    5'd11: r = a - b;
                    5'd12: r = a * b;
                    default: begin
                        if (b == 32'd0) begin
                            r = 32'd0;
                            ref_err = 1'b1;
                        end else begin
                            r = a / b;
                            lat = 34;
                        end
                    end
                endcase
                ref_stk.push_back(r);
                ref_entry = 1'b0;
            end
        end else if (k == 5'd14) begin
            if (sz < 64) begin
                ref_stk.push_back(32'd0);
                ref_entry = 1'b1;
                lat = 1;
            end else ref_err = 1'b1;
        end else if (k == 5'd15) begin
            ref_stk[sz-1] = 32'd0;
            ref_err = 1'b0;
            ref_entry = 1'b1;
            lat = 1;
        end
    endtask

    // Present one key, wait for completion while poking ignored keys, compare.
    task automatic press(input logic [4:0] k);
        int exp_lat, n;
        @(negedge clock);
        chk("key_ready", 32'(bus.key_ready), 32'd1);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        model_key(k, exp_lat);
        @(negedge clock);
        bus.key_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            bus.key_valid = 1'($urandom_range(0, 1));
            bus.key_code  = 5'($urandom);
            @(negedge clock);
        end
        bus.key_valid = 1'b0;
        last_lat = n;
        chk($sformatf("lat_k%0d", k), 32'(n), 32'(exp_lat));
        chk($sformatf("cnt_k%0d", k), 32'(stk_cnt), 32'(ref_stk.size()));
        chk($sformatf("top_k%0d", k), bus.stack_top, ref_stk[$]);
        chk($sformatf("err_k%0d", k), 32'(bus.err), 32'(ref_err));
    endtask

    task automatic collapse();
        while (ref_stk.size() > 1) press(5'd10);
    endtask

    function automatic logic [4:0] rand_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      return 5'($urandom_range(0, 9));
        else if (r < 57) return 5'd14;
        else if (r < 82) return 5'($urandom_range(10, 13));
        else if (r < 86) return 5'd15;
        else             return 5'($urandom_range(16, 31));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.key_ready), 32'd1);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_push"},  32'(bus.push),      32'd0);
        chk({tag, "_pop"},   32'(bus.pop),       32'd0);
        chk({tag, "_write"}, 32'(bus.write),     32'd0);
        chk({tag, "_value"}, bus.value,          32'd0);
        chk({tag, "_err"},   32'(bus.err),       32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 5'd0;
        #5 reset_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_outputs("rst_rel");

        // refused add on a single element
        press(5'd10);
        chk("add1_err", 32'(bus.err), 32'd1);
        chk("add1_cnt", 32'(stk_cnt), 32'd1);
        press(5'd15);
        chk("clr_err", 32'(bus.err), 32'd0);

        // open-number digit entry
        press(5'd1); press(5'd2); press(5'd3);
        chk("digits_top", bus.stack_top, 32'd123);
        chk("digits_cnt", 32'(stk_cnt), 32'd1);

        // 7 ENTER 5 + then new-number 4
        press(5'd15);
        press(5'd7); press(5'd14); press(5'd5); press(5'd10);
        chk("add_top", bus.stack_top, 32'd12);
        chk("add_cnt", 32'(stk_cnt), 32'd1);
        press(5'd4);
        chk("new_top", bus.stack_top, 32'd4);
        chk("new_cnt", 32'(stk_cnt), 32'd2);
        collapse();

        // 100 / 7 and divide by zero
        press(5'd15);
        press(5'd1); press(5'd0); press(5'd0); press(5'd14); press(5'd7); press(5'd13);
        chk("div_lat", 32'(last_lat), 32'd34);
        chk("div_top", bus.stack_top, 32'd14);
        chk("div_cnt", 32'(stk_cnt), 32'd1);
        press(5'd9); press(5'd14); press(5'd0); press(5'd13);
        chk("div0_top", bus.stack_top, 32'd0);
        chk("div0_err", 32'(bus.err), 32'd1);
        press(5'd15);
        chk("div0_clr", 32'(bus.err), 32'd0);

        // wrapping sub and mul
        press(5'd0); press(5'd14); press(5'd1); press(5'd11);
        chk("sub_wrap", bus.stack_top, 32'hFFFF_FFFF);
        press(5'd6); press(5'd5); press(5'd5); press(5'd3); press(5'd6); press(5'd14);
        press(5'd6); press(5'd5); press(5'd5); press(5'd3); press(5'd6); press(5'd12);
        chk("mul_wrap", bus.stack_top, 32'd0);
        collapse();

        // fill the stack, then one ENTER too many
        repeat (63) press(5'd14);
        chk("full_code", 32'(bus.stack_count), 32'd0);
        press(5'd14);
        chk("full_err", 32'(bus.err), 32'd1);
        chk("full_cnt", 32'(stk_cnt), 32'd64);
        collapse();

        // randomized key stream
        for (int i = 0; i < 400; i++) press(rand_key());

        // reset during the divider
        collapse();
        press(5'd15);
        press(5'd1); press(5'd0); press(5'd0); press(5'd14); press(5'd7);
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_code  = 5'd13;
        @(negedge clock);
        bus.key_valid = 1'b0;
        chk("div_busy", 32'(bus.busy), 32'd1);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        ref_err   = 1'b0;
        ref_entry = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("mid_rst_cnt", 32'(stk_cnt), 32'd2);
        chk("mid_rst_top", bus.stack_top, 32'd7);
        press(5'd3);
        chk("after_rst_top", bus.stack_top, 32'd73);
        press(5'd13);
        chk("after_rst_div", bus.stack_top, 32'd1);

        // global invariants and full contents
        chk("strobe_excl", 32'(multi), 32'd0);
        chk("stack_err", 32'(stk_bad), 32'd0);
        for (int i = 0; i < ref_stk.size(); i++)
            chk($sformatf("mem%0d", i), mem[6'(i)], ref_stk[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
